// File: rtl/bsg_yumi_to_ready_fifo.sv
// bsg_yumi_to_ready_fifo
//   Small circular FIFO that accepts from a valid/yumi producer and presents a
//   valid/ready interface downstream. The upstream acknowledge (yumi_o) is
//   computed only from v_i and local state, so no combinational path exists
//   from ready_i to yumi_o. Consequence: when full, a slot freed by a dequeue
//   is only reused on the following cycle.
//
//   Optional occupancy counter output (count_o) is compiled in when the macro
//   BSG_YUMI_TO_READY_FIFO_COUNT_EN is defined; the default build omits it.
module bsg_yumi_to_ready_fifo #(
    parameter int width_p = 16,
    parameter int els_p   = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   yumi_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    input  logic                   ready_i
`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
    ,
    output logic [$clog2(els_p):0] count_o
`endif
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp = ptr_w_lp'(1);

    // Elaboration-time parameter checks.
    if (els_p < 2 || els_p > 16 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
        $error("bsg_yumi_to_ready_fifo: els_p must be a power of two in 2..16");
    end
    if (width_p < 1) begin : g_bad_width
        $error("bsg_yumi_to_ready_fifo: width_p must be >= 1");
    end

    // State
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];

    logic                enq;
    logic                deq;
    logic [ptr_w_lp-1:0] wptr_inc;
    logic [ptr_w_lp-1:0] rptr_inc;

    // Handshake outputs: yumi never looks at ready_i, v_o never looks at ready_i.
    always_comb begin
        yumi_o = v_i & ~full_q & ~reset_i;
        v_o    = ~empty_q;
        data_o = mem_q[rptr_q];
        enq    = yumi_o;
        deq    = v_o & ready_i;
    end

    // Next-state for pointers and full/empty flags; reset wins over any transfer.
    always_comb begin
        wptr_inc = wptr_q + ptr_one_lp;
        rptr_inc = rptr_q + ptr_one_lp;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        full_d   = full_q;
        empty_d  = empty_q;
        if (reset_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            full_d  = 1'b0;
            empty_d = 1'b1;
        end else begin
            if (enq) wptr_d = wptr_inc;
            if (deq) rptr_d = rptr_inc;
            case ({enq, deq})
                2'b10: begin
                    empty_d = 1'b0;
                    full_d  = (wptr_inc == rptr_q);
                end
                2'b01: begin
                    full_d  = 1'b0;
                    empty_d = (rptr_inc == wptr_q);
                end
                default: ;  // both or neither: flags hold
            endcase
        end
    end

    // Storage write: only the slot under the write pointer changes on enqueue.
    always_comb begin
        mem_d = mem_q;
        if (enq) mem_d[wptr_q] = data_i;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        full_q  <= full_d;
        empty_q <= empty_d;
    end

    // Payload storage register; intentionally not reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
    localparam logic [ptr_w_lp:0] cnt_one_lp  = (ptr_w_lp + 1)'(1);
    localparam logic [ptr_w_lp:0] cnt_full_lp = (ptr_w_lp + 1)'(els_p);

    logic [ptr_w_lp:0] cnt_q, cnt_d;

    // Occupancy counter: +1 on enqueue only, -1 on dequeue only.
    always_comb begin
        cnt_d = cnt_q;
        if (reset_i)          cnt_d = '0;
        else if (enq && !deq) cnt_d = cnt_q + cnt_one_lp;
        else if (deq && !enq) cnt_d = cnt_q - cnt_one_lp;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

    a_cnt_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        (cnt_q == '0) == empty_q)
        else $error("bsg_yumi_to_ready_fifo: counter/empty disagree");
    a_cnt_full: assert property (@(posedge clk_i) disable iff (reset_i)
        (cnt_q == cnt_full_lp) == full_q)
        else $error("bsg_yumi_to_ready_fifo: counter/full disagree");
`endif

    // Protocol sanity checks (ignored by synthesis flows).
    a_no_deq_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        deq |-> !empty_q)
        else $error("bsg_yumi_to_ready_fifo: dequeue while empty");
    a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i)
        enq |-> !full_q)
        else $error("bsg_yumi_to_ready_fifo: enqueue while full");
    a_head_stable: assert property (@(posedge clk_i) disable iff (reset_i)
        (v_o && !ready_i) |=> $stable(data_o))
        else $error("bsg_yumi_to_ready_fifo: head changed without dequeue");

endmodule

// File: tb/tb_bsg_yumi_to_ready_fifo.sv
// Bench for bsg_yumi_to_ready_fifo: instance A (els_p=2) runs directed
// vectors, instance B (els_p=4) runs a 10,000-item random-handshake stream.
// Drivers push accepted payloads into per-instance queues; negedge monitors
// pop and compare whenever a downstream transfer is presented, and also
// compare v_o / yumi_o (and count_o when enabled) against an occupancy model.
module tb_bsg_yumi_to_ready_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A signals (els_p = 2)
    logic        a_rst, a_v, a_yumi, a_vo, a_rdy;
    logic [15:0] a_di, a_do;
    // Instance B signals (els_p = 4)
    logic        b_rst, b_v, b_yumi, b_vo, b_rdy;
    logic [15:0] b_di, b_do;
`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
    logic [1:0]  a_cnt;
    logic [2:0]  b_cnt;
`endif

    logic [15:0] a_sb[$];
    logic [15:0] b_sb[$];
    int          a_occ = 0;
    int          b_occ = 0;
    int          b_delivered = 0;

    bsg_yumi_to_ready_fifo #(.width_p(16), .els_p(2)) u_a (
        .clk_i(clk), .reset_i(a_rst), .v_i(a_v), .data_i(a_di), .yumi_o(a_yumi),
        .v_o(a_vo), .data_o(a_do), .ready_i(a_rdy)
`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
        , .count_o(a_cnt)
`endif
    );

    bsg_yumi_to_ready_fifo #(.width_p(16), .els_p(4)) u_b (
        .clk_i(clk), .reset_i(b_rst), .v_i(b_v), .data_i(b_di), .yumi_o(b_yumi),
        .v_o(b_vo), .data_o(b_do), .ready_i(b_rdy)
`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
        , .count_o(b_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor A: model-based handshake checks plus scoreboard pop.
    always @(negedge clk) begin
        if (a_rst) begin
            a_sb.delete();
            a_occ = 0;
            chk("a_reset_yumi", {31'b0, a_yumi}, 0);
        end else begin
            chk("a_v_o", {31'b0, a_vo}, a_occ != 0);
            chk("a_yumi", {31'b0, a_yumi}, a_v && a_occ < 2);
`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
            chk("a_count", {30'b0, a_cnt}, a_occ);
`endif
            if (a_vo && a_rdy) begin
                if (a_sb.size() == 0) chk("a_sb_underflow", 1, 0);
                else chk("a_data", {16'b0, a_do}, {16'b0, a_sb.pop_front()});
            end
            a_occ = a_occ + ((a_v && a_occ < 2) ? 1 : 0) - ((a_occ != 0 && a_rdy) ? 1 : 0);
        end
    end

    // Monitor B: same checks for the deeper instance.
    always @(negedge clk) begin
        if (b_rst) begin
            b_sb.delete();
            b_occ = 0;
            chk("b_reset_yumi", {31'b0, b_yumi}, 0);
        end else begin
            chk("b_v_o", {31'b0, b_vo}, b_occ != 0);
            chk("b_yumi", {31'b0, b_yumi}, b_v && b_occ < 4);
`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
            chk("b_count", {29'b0, b_cnt}, b_occ);
`endif
            if (b_vo && b_rdy) begin
                if (b_sb.size() == 0) chk("b_sb_underflow", 1, 0);
                else chk("b_data", {16'b0, b_do}, {16'b0, b_sb.pop_front()});
                b_delivered++;
            end
            b_occ = b_occ + ((b_v && b_occ < 4) ? 1 : 0) - ((b_occ != 0 && b_rdy) ? 1 : 0);
        end
    end

    // One cycle on A; returns what the DUT showed before the next edge.
    task automatic a_cyc(input logic rst, input logic v, input logic [15:0] d, input logic rdy,
                         output logic yumi, output logic vo, output logic [15:0] dout);
        @(posedge clk); #1;
        a_rst = rst; a_v = v; a_di = d; a_rdy = rdy;
        @(negedge clk);
        yumi = a_yumi; vo = a_vo; dout = a_do;
        if (!rst && v && a_yumi) a_sb.push_back(d);
    endtask

    task automatic b_cyc(input logic v, input logic [15:0] d, input logic rdy, output logic yumi);
        @(posedge clk); #1;
        b_rst = 1'b0; b_v = v; b_di = d; b_rdy = rdy;
        @(negedge clk);
        yumi = b_yumi;
        if (v && b_yumi) b_sb.push_back(d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        y, vo, v, r;
        logic [15:0] dd, nxt;
        logic        exp_y[5];
        logic [15:0] exp_d[5];
        int          item;

        a_rst = 1'b1; a_v = 1'b1; a_di = 16'hA5A5; a_rdy = 1'b0;
        b_rst = 1'b1; b_v = 1'b0; b_di = 16'h0;    b_rdy = 1'b0;
        repeat (2) @(posedge clk);

        // Fill A with A5A5 while downstream stalls: 1,1 then full.
        a_cyc(0, 1, 16'hA5A5, 0, y, vo, dd);
        chk("fill_c1_yumi", {31'b0, y}, 1); chk("fill_c1_v_o", {31'b0, vo}, 0);
        a_cyc(0, 1, 16'hA5A5, 0, y, vo, dd);
        chk("fill_c2_yumi", {31'b0, y}, 1); chk("fill_c2_v_o", {31'b0, vo}, 1);
        chk("fill_c2_data", {16'b0, dd}, 16'hA5A5);
        a_cyc(0, 1, 16'hA5A5, 0, y, vo, dd);
        chk("fill_c3_yumi", {31'b0, y}, 0); chk("fill_c3_v_o", {31'b0, vo}, 1);

        // Release from full: first cycle is dequeue only, then 1/cycle.
        exp_y = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_d = '{16'hA5A5, 16'hA5A5, 16'hB001, 16'hB002, 16'hB003};
        nxt = 16'hB001;
        for (int i = 0; i < 5; i++) begin
            a_cyc(0, 1, nxt, 1, y, vo, dd);
            chk("drain_yumi", {31'b0, y}, {31'b0, exp_y[i]});
            chk("drain_data", {16'b0, dd}, {16'b0, exp_d[i]});
            if (y) nxt = nxt + 16'd1;
        end
        repeat (2) a_cyc(0, 0, 16'h0, 1, y, vo, dd);

        // Single pulse into an empty FIFO with ready held high.
        a_cyc(0, 1, 16'h0001, 1, y, vo, dd);
        chk("pulse_c0_v_o", {31'b0, vo}, 0);
        a_cyc(0, 0, 16'h0, 1, y, vo, dd);
        chk("pulse_c1_v_o", {31'b0, vo}, 1); chk("pulse_c1_data", {16'b0, dd}, 16'h0001);
        a_cyc(0, 0, 16'h0, 1, y, vo, dd);
        chk("pulse_c2_v_o", {31'b0, vo}, 0);

        // Reset with two entries held: everything discarded, BEEF delivered first.
        a_cyc(0, 1, 16'h1111, 0, y, vo, dd);
        a_cyc(0, 1, 16'h2222, 0, y, vo, dd);
        a_cyc(1, 1, 16'h3333, 0, y, vo, dd);
        chk("rst_mid_yumi", {31'b0, y}, 0);
        a_cyc(0, 1, 16'hBEEF, 0, y, vo, dd);
        chk("post_rst_v_o", {31'b0, vo}, 0); chk("post_rst_yumi", {31'b0, y}, 1);
        a_cyc(0, 0, 16'h0, 1, y, vo, dd);
        chk("post_rst_first_v", {31'b0, vo}, 1); chk("post_rst_first_d", {16'b0, dd}, 16'hBEEF);
        a_cyc(0, 0, 16'h0, 1, y, vo, dd);
        chk("post_rst_empty", {31'b0, vo}, 0);

`ifdef BSG_YUMI_TO_READY_FIFO_COUNT_EN
        // Occupancy: enq,enq,deq,deq,enq,enq+deq,deq -> 0,1,2,1,0,1,1,0 sampled.
        begin
            logic [1:0] cv[8], cr[8], ce[8];
            cv = '{1, 1, 0, 0, 1, 1, 0, 0};
            cr = '{0, 0, 1, 1, 0, 1, 1, 0};
            ce = '{0, 1, 2, 1, 0, 1, 1, 0};
            for (int i = 0; i < 8; i++) begin
                a_cyc(0, cv[i][0], 16'hC000 + 16'(i), cr[i][0], y, vo, dd);
                chk("count_seq", {30'b0, a_cnt}, {30'b0, ce[i]});
            end
        end
`endif
        chk("a_sb_drained", a_sb.size(), 0);

        // Random stream on B: 10,000 incrementing payloads, in order, no loss.
        b_rst = 1'b0;
        item = 0;
        while (item < 10000) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            b_cyc(v, item[15:0], r, y);
            if (v && y) item++;
        end
        for (int i = 0; i < 40 && b_sb.size() != 0; i++) b_cyc(0, 16'h0, 1, y);
        chk("b_drain_bound", b_sb.size(), 0);
        b_cyc(0, 16'h0, 1, y);
        chk("b_delivered", b_delivered, 10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
